// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier.
//   STATE_W     : width of the controller state encoding
//   state_t     : controller states IDLE / BUSY / DONE
//   iter_width  : width of an iteration counter able to hold 0..n-1
package mult_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-iteration configuration still needs a 1-bit counter.
  function automatic int iter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_step.sv
// One radix-2^STEP iteration of the shift-and-add multiplier (combinational).
//   acc_in  : running 2*WIDTH-bit partial sum
//   a_reg   : registered multiplicand (magnitude)
//   digit   : current STEP-bit digit of the multiplier
//   iter    : iteration index, selects the shift of this partial product
//   acc_out : acc_in + (a_reg * digit) << (iter*STEP)
module mult_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2,
  localparam int N     = WIDTH / STEP,
  localparam int CNT_W = iter_width(N),
  localparam int PW    = 2 * WIDTH
) (
  input  logic [PW-1:0]    acc_in,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [STEP-1:0]  digit,
  input  logic [CNT_W-1:0] iter,
  output logic [PW-1:0]    acc_out
);

  localparam int SH_W = $clog2(PW);

  logic [PW-1:0]   partial;
  logic [SH_W-1:0] shamt;

  always_comb begin
    partial = {{WIDTH{1'b0}}, a_reg} * {{(PW-STEP){1'b0}}, digit};
    shamt   = SH_W'(iter) * SH_W'(STEP);
    acc_out = acc_in + (partial << shamt);
  end

endmodule

// File: rtl/multiplier_seq.sv
// Sequential shift-and-add multiplier retiring STEP multiplier bits per cycle.
// Fixed latency of N = WIDTH/STEP cycles from the accepting edge to out_valid.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised by the producer side of this block (out_valid), is
// held with product stable until the matching ready is seen.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : operand handshake (a, b, is_signed)
//   out_valid/ready : result handshake (product, 2*WIDTH bits)
//
// Build option: define MULTIPLIER_SEQ_SIGNED_EN to honour is_signed
// (two's complement operands). Without it is_signed is ignored.
module multiplier_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int STEP  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = iter_width(N);
  localparam int PW    = 2 * WIDTH;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]    acc, acc_next, result;
  logic [CNT_W-1:0] iter;
  logic             accept, last;

  assign accept = in_valid && in_ready;
  assign last   = (state == BUSY) && (iter == CNT_W'(N - 1));

`ifdef MULTIPLIER_SEQ_SIGNED_EN
  logic neg;

  // Magnitudes are taken at acceptance; the unsigned iteration then runs as
  // usual. The most-negative value maps to itself, which is its correct
  // unsigned magnitude.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? (~a) + WIDTH'(1) : a;
    b_mag = (is_signed && b[WIDTH-1]) ? (~b) + WIDTH'(1) : b;
  end

  assign result = neg ? (~acc_next) + PW'(1) : acc_next;
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = acc_next;
`endif

  mult_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .acc_in  (acc),
    .a_reg   (a_reg),
    .digit   (b_reg[STEP-1:0]),
    .iter    (iter),
    .acc_out (acc_next)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        // Taking the result and new operands on the same edge goes straight
        // back to BUSY.
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: multiplier digits are consumed from the low end of b_reg.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      iter    <= '0;
      product <= '0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a_mag;
      b_reg <= b_mag;
      acc   <= '0;
      iter  <= '0;
`ifdef MULTIPLIER_SEQ_SIGNED_EN
      neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
    end else if (state == BUSY) begin
      acc   <= acc_next;
      b_reg <= b_reg >> STEP;
      iter  <= iter + CNT_W'(1);
      if (last) product <= result;
    end
  end

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq (WIDTH=16, STEP=2).
// Directed cases, stall/back-to-back, mid-operation reset and randomized
// operations are scored against an arithmetic reference model.
module tb_multiplier_seq;

  localparam int W  = 16;
  localparam int PW = 2 * W;
  localparam int LAT = 8;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, is_signed, out_valid, out_ready;
  logic [W-1:0]  a, b;
  logic [PW-1:0] product;

  int n_cmp = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  always #5 clk = ~clk;

  multiplier_seq #(.WIDTH(W), .STEP(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking / model ----------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] ref_product(input logic [W-1:0] x, input logic [W-1:0] y,
                                                 input logic s);
    longint sx, sy;
    sx = longint'(x);
    sy = longint'(y);
    if (s && SIGNED_EN) begin
      if (x[W-1]) sx = sx - (longint'(1) << W);
      if (y[W-1]) sy = sy - (longint'(1) << W);
    end
    return PW'(sx * sy);
  endfunction

  // Scoreboard: every output handshake must match the oldest accepted operation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check_eq("spurious_out", out_valid, 1'b0);
      else                   check_eq("product", product, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq("in_ready_wait", in_ready, 1'b1);
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    is_signed = s;
    @(posedge clk);
    exp_q.push_back(ref_product(x, y, s));
    #1;
    in_valid  = 1'b0;
    a         = W'($urandom);
    b         = W'($urandom);
    is_signed = 1'($urandom_range(0, 1));
  endtask

  // Count edges after acceptance until out_valid rises (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) check_eq("busy_in_ready", in_ready, 1'b0);
    end while (!out_valid && cyc < 40);
  endtask

  // One complete operation, optionally stalling the consumer in DONE.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                    input int stall, output logic [PW-1:0] seen);
    int c;
    send(x, y, s);
    wait_done(c);
    check_eq("latency", c, LAT);
    seen = product;
    if (stall > 0) begin
      out_ready = 1'b0;
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_product", product, seen);
        check_eq("stall_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [PW-1:0] p, p_hold;
    logic          seen_valid;
    int            c;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_product", product, '0);
    rst = 1'b0;

    // Directed values
    op(16'd3, 16'd5, 1'b0, 0, p);
    check_eq("p_3x5", p, 32'h0000_000F);
    op(16'h0000, 16'hFFFF, 1'b0, 0, p);
    check_eq("p_0xffff", p, 32'h0);
    op(16'hFFFF, 16'hFFFF, 1'b0, 0, p);
    check_eq("p_ffff_sq", p, 32'hFFFE_0001);
    op(16'hFFFF, 16'h0001, 1'b1, 0, p);
    check_eq("p_m1x1", p, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_FFFF);
    op(16'h8000, 16'h8000, 1'b1, 0, p);
    check_eq("p_minneg_sq", p, 32'h4000_0000);

    // Stall 5 cycles in DONE, then simultaneous output and input handshake
    send(16'd1234, 16'd5678, 1'b0);
    wait_done(c);
    check_eq("stall_latency", c, LAT);
    out_ready = 1'b0;
    p_hold = product;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_product", product, p_hold);
      check_eq("hold_in_ready", in_ready, 1'b0);
    end
    check_eq("hold_value", p_hold, ref_product(16'd1234, 16'd5678, 1'b0));
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1357; is_signed = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    exp_q.push_back(ref_product(16'hABCD, 16'h1357, 1'b0));
    #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
    check_eq("b2b_busy_valid", out_valid, 1'b0);
    check_eq("b2b_busy_ready", in_ready, 1'b0);
    c = 0;
    while (!out_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    check_eq("b2b_latency", c, LAT);
    check_eq("b2b_product", product, ref_product(16'hABCD, 16'h1357, 1'b0));
    @(posedge clk); #1;

    // Reset at edge 4 of BUSY: the operation is discarded
    send(16'h7777, 16'h0F0F, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    check_eq("abort_product", product, '0);
    seen_valid = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      seen_valid = seen_valid | out_valid;
    end
    check_eq("abort_quiet", seen_valid, 1'b0);

    // Randomized operations with random consumer stalls
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      logic         s;
      x = W'($urandom);
      y = W'($urandom);
      case ($urandom_range(0, 5))
        0: x = 16'h8000;
        1: y = 16'hFFFF;
        2: x = 16'h0000;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      op(x, y, s, $urandom_range(0, 3), p);
      check_eq("rand_product", p, ref_product(x, y, s));
    end

    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have parameter STEP, default 2, multiplier bits retired per cycle; legal values are 1, 2 or 4, and STEP SHALL divide WIDTH.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b and is_signed are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-008 SHALL have port b, input, WIDTH bits: multiplier.
REQ-009 SHALL have port is_signed, input, 1 bit: treat a and b as two's complement.
REQ-010 SHALL have port out_valid, output, 1 bit: product is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the consumer takes the product.
REQ-012 SHALL have port product, output, 2*WIDTH bits: result.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 SHALL accept operands on an edge where in_valid && in_ready is true (edge 0), registering a, b and is_signed and moving to BUSY.
REQ-015 SHALL, in BUSY, add (a_reg * next STEP-bit digit of b_reg), shifted into place, to a 2*WIDTH accumulator on each edge; N = WIDTH/STEP iterations occur on edges 1..N.
REQ-016 SHALL enter DONE after edge N with out_valid=1 and product stable; fixed latency is N cycles with no early termination for zero or small operands.
REQ-017 SHALL drive in_ready=1 in IDLE, 0 in BUSY, and equal to out_ready in DONE.
REQ-018 SHALL, in DONE, hold out_valid and product unchanged until out_ready=1.
REQ-019 SHALL, on an edge in DONE with out_ready=1, go to BUSY if in_valid=1 (simultaneous output and input handshake, back-to-back), else to IDLE.
REQ-020 SHALL ignore a, b and is_signed outside an accepting edge; operand changes during BUSY have no effect.
REQ-021 SHALL compute unsigned products exactly modulo 2^(2*WIDTH); no overflow is possible.
REQ-022 SHALL hold product at its last value when out_valid=0; consumers use product only when out_valid=1.

Reset
REQ-023 SHALL, on an edge with rst=1 in any state (including mid-BUSY), set the state to IDLE, out_valid=0, the accumulator and product to 0, and in_ready=1 from the next cycle.
REQ-024 SHALL give rst priority over every handshake on the same edge; an operation in progress is discarded and produces no output.

Configuration
REQ-025 SHALL, with MULTIPLIER_SEQ_SIGNED_EN defined and is_signed=1, compute the signed product by taking operand magnitudes at acceptance, running the unsigned iteration, and negating the result in DONE entry when the operand signs differ; latency is unchanged.
REQ-026 SHALL handle the most-negative case exactly: (-2^(WIDTH-1)) * (-2^(WIDTH-1)) = 2^(2*WIDTH-2).
REQ-027 SHALL, without MULTIPLIER_SEQ_SIGNED_EN, keep the is_signed port, ignore it, and always produce the unsigned product; no sign or negation logic is synthesised.

Structure
REQ-028 SHALL place the state enum (IDLE/BUSY/DONE) and the state-width constant in shared package mult_pkg.
REQ-029 SHALL use one sub-module, mult_step, combinational: accumulator + (a_reg * digit) << (iteration*STEP), parametrised by WIDTH and STEP.

Verification (WIDTH=16, STEP=2, N=8)
REQ-030 SHALL verify: a=3, b=5, is_signed=0 accepted at edge 0 -> out_valid after edge 8, product=0x0000000F; a=0, b=0xFFFF -> product 0 at the same latency.
REQ-031 SHALL verify: a=0xFFFF, b=0xFFFF, unsigned -> product=0xFFFE0001.
REQ-032 SHALL verify: a=0xFFFF, b=0x0001, is_signed=1 -> 0xFFFFFFFF with the macro, 0x0000FFFF without it; a=b=0x8000 signed -> 0x40000000.
REQ-033 SHALL verify: out_ready held 0 for 5 cycles in DONE -> out_valid and product stable and in_ready=0; then out_ready=1 with in_valid=1 -> result taken and new operation in BUSY on the same edge.
REQ-034 SHALL verify: rst=1 at edge 4 of BUSY -> out_valid=0 and in_ready=1 the next cycle, and no product is ever emitted for the aborted operation.
